instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
- Fetches 32-bit SoftMC instructions from the host instruction FIFO over a valid/ready handshake.
- Interprets control instructions itself (WAIT, BUSDIR, END) and forwards DDR command instructions, one per cycle, to the combinational instr_decoder as en/instr.
- Sits directly upstream of instr_decoder. Its registered dec_en/dec_instr outputs drive the decoder's en/instr inputs.

Parameters:
- INSTR_W, 32, instruction width.
- WAIT_W, 16, width of the wait counter; WAIT count is taken from instr[WAIT_W-1:0].

Ports:
- clk  input  1  DFI-domain clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  pulse; begins executing a sequence (ignored unless IDLE).
- abort  input  1  synchronous; terminates the sequence immediately.
- in_valid  input  1  FIFO has an instruction.
- in_data  input  INSTR_W  instruction word.
- in_ready  output  1  sequencer pops in_data this cycle when in_valid=1.
- dec_en  output  1  to instr_decoder en.
- dec_instr  output  INSTR_W  to instr_decoder instr.
- busdir  output  1  bus direction (1=read), consumed by the dispatcher/PHY.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when END executes.
- err  output  1  sticky; set on an unknown type code, cleared on an accepted start.

Behaviour:
- Type field is in_data[31:28], with these codes:
  - DDR = 4'b0100.
  - WAIT = 4'b0001.
  - BUSDIR = 4'b0010.
  - END = 4'b1111.
  - Any other code is unknown.
- Reset (async, rst_n=0) values:
  - state=IDLE.
  - in_ready=0, dec_en=0, dec_instr=0.
  - busdir=0, busy=0, done=0, err=0.
  - wait counter=0.
- Accept condition: a word is accepted when in_valid & in_ready. in_ready is combinational and equals (state==RUN) & ~abort.
- IDLE:
  - in_ready=0, dec_en=0.
  - start=1 -> RUN next cycle, and err is cleared.
- RUN, on accept:
  - DDR: dec_instr<=in_data and dec_en<=1 for exactly the next cycle (1-cycle latency). State stays RUN. Back-to-back DDR words yield dec_en high on consecutive cycles.
  - WAIT with N=instr[WAIT_W-1:0]:
    - N=0: no-op, stay RUN.
    - N>=1: counter<=N-1, go to WAIT.
  - BUSDIR: busdir<=instr[0] next cycle, stay RUN.
  - END: go to DONE.
  - Unknown type: err<=1, treated as a no-op, stay RUN.
- RUN, no accept: dec_en<=0 next cycle. dec_instr holds its last value.
- WAIT:
  - in_ready=0, dec_en=0.
  - If counter==0 -> RUN; otherwise decrement.
  - Timing: a WAIT N accepted at cycle t allows the next accept at t+N+1.
  - The counter never wraps below 0.
- DONE: done=1 for one cycle, busy=1, then -> IDLE.
- abort=1 in any non-IDLE state:
  - Next state is IDLE; counter cleared; dec_en<=0.
  - No done pulse; busdir and err retained.
  - The same-cycle FIFO word is not popped (in_ready forced 0).
- Simultaneous events:
  - start with abort in IDLE: abort wins, stay IDLE.
  - start while busy: ignored.
- Empty FIFO in RUN: the sequencer stalls with dec_en=0 indefinitely and no timeout.
- dec_en, dec_instr and busdir are all registered. No combinational path exists from in_data to any output.

Decomposition:
- Package softmc_seq_pkg holds:
  - Type codes (TYPE_DDR, TYPE_WAIT, TYPE_BUSDIR, TYPE_END).
  - TYPE_MSB/LSB field offsets.
  - The state enum {IDLE, RUN, WAIT, DONE}.
- Sub-module seq_wait_counter (load, value, dec, zero) is natural and keeps the FSM file focused on decode.

Test Plan:
- Basic sequence: start, then FIFO DDR 0x40000123, DDR 0x40000456, END.
  - dec_en high for 2 consecutive cycles carrying those words.
  - done pulses once 1 cycle after END is accepted.
  - busy falls the same cycle as done's falling edge.
- WAIT 5 between two DDR words:
  - The second DDR word is accepted exactly 6 cycles after the WAIT accept.
  - dec_en=0 for those intervening cycles.
  - WAIT 0 gives back-to-back accepts.
- BUSDIR 0x20000001 -> busdir=1 next cycle; BUSDIR 0x20000000 -> busdir=0.
- Unknown type 0x70000000 mid-sequence:
  - err=1 and stays 1 through END.
  - Sequence continues normally.
  - Next start clears err.
- Abort during WAIT 100 at count 50:
  - IDLE next cycle, in_ready=0, no done.
  - A following start plus DDR word issues normally.
- rst_n asserted mid-RUN with dec_en=1:
  - All outputs drop to reset values immediately, without a clock edge.
  - start is ignored while rst_n=0.

Source files
------------

// File: rtl/softmc_seq_pkg.sv
// softmc_seq_pkg
//   Shared definitions for the SoftMC instruction sequencer: instruction
//   type-field location, type codes and the sequencer state encoding.
package softmc_seq_pkg;

  // Type field occupies instr[31:28]
  localparam int unsigned TYPE_MSB = 31;
  localparam int unsigned TYPE_LSB = 28;

  localparam logic [3:0] TYPE_DDR    = 4'b0100;
  localparam logic [3:0] TYPE_WAIT   = 4'b0001;
  localparam logic [3:0] TYPE_BUSDIR = 4'b0010;
  localparam logic [3:0] TYPE_END    = 4'b1111;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    WAIT,
    DONE
  } seq_state_t;

endpackage

// File: rtl/seq_wait_counter.sv
// seq_wait_counter
//   Down-counter used by the sequencer's WAIT state.
//   clk, rst_n : clock, asynchronous active-low reset (count -> 0)
//   load       : load value (has priority over dec)
//   value      : count to load
//   dec        : decrement by one; holds at zero, never wraps
//   zero       : count == 0
module seq_wait_counter #(
  parameter int unsigned WAIT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [WAIT_W-1:0] value,
  input  logic              dec,
  output logic              zero
);

  logic [WAIT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (dec && (count != '0)) begin
      count <= count - WAIT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer
//   Pops 32-bit SoftMC instructions from the host FIFO, executes control
//   instructions (WAIT, BUSDIR, END) locally and forwards DDR instructions
//   to instr_decoder, one per cycle, with one cycle of latency.
//   clk, rst_n        : DFI clock, asynchronous active-low reset
//   start             : pulse, starts a sequence when IDLE
//   abort             : synchronous, ends the sequence at once
//   in_valid/in_data  : FIFO word; popped when in_valid & in_ready
//   in_ready          : (state == RUN) & ~abort
//   dec_en/dec_instr  : registered drive into instr_decoder en/instr
//   busdir            : registered bus direction (1 = read)
//   busy              : high outside IDLE
//   done              : one-cycle pulse after END is accepted
//   err               : sticky unknown-type flag, cleared on accepted start
module instr_sequencer
  import softmc_seq_pkg::*;
#(
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned WAIT_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic               in_valid,
  input  logic [INSTR_W-1:0] in_data,
  output logic               in_ready,
  output logic               dec_en,
  output logic [INSTR_W-1:0] dec_instr,
  output logic               busdir,
  output logic               busy,
  output logic               done,
  output logic               err
);

  seq_state_t        state;
  logic [3:0]        instr_type;
  logic [WAIT_W-1:0] wait_n;
  logic              accept;
  logic              cnt_load;
  logic [WAIT_W-1:0] cnt_value;
  logic              cnt_dec;
  logic              cnt_zero;

  assign instr_type = in_data[TYPE_MSB:TYPE_LSB];
  assign wait_n     = in_data[WAIT_W-1:0];
  assign in_ready   = (state == RUN) && !abort;
  assign accept     = in_valid && in_ready;

  // Loading zero doubles as the abort clear, so the counter needs no
  // separate clear input.
  always_comb begin
    cnt_load  = 1'b0;
    cnt_value = '0;
    cnt_dec   = 1'b0;
    if (abort && (state != IDLE)) begin
      cnt_load = 1'b1;
    end else if (accept && (instr_type == TYPE_WAIT) && (wait_n != '0)) begin
      cnt_load  = 1'b1;
      cnt_value = wait_n - WAIT_W'(1);
    end else if (state == WAIT) begin
      cnt_dec = 1'b1;
    end
  end

  seq_wait_counter #(
    .WAIT_W(WAIT_W)
  ) u_wait_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (cnt_load),
    .value (cnt_value),
    .dec   (cnt_dec),
    .zero  (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      dec_en    <= 1'b0;
      dec_instr <= '0;
      busdir    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      dec_en <= 1'b0;
      done   <= 1'b0;
      if (state == IDLE) begin
        if (start && !abort) begin
          state <= RUN;
          busy  <= 1'b1;
          err   <= 1'b0;
        end
      end else if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        unique case (state)
          RUN: begin
            if (accept) begin
              case (instr_type)
                TYPE_DDR: begin
                  dec_instr <= in_data;
                  dec_en    <= 1'b1;
                end
                TYPE_WAIT: begin
                  if (wait_n != '0) state <= WAIT;
                end
                TYPE_BUSDIR: busdir <= in_data[0];
                TYPE_END: begin
                  state <= DONE;
                  done  <= 1'b1;
                end
                default: err <= 1'b1;
              endcase
            end
          end
          WAIT: begin
            if (cnt_zero) state <= RUN;
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned WAIT_W  = 16;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic               abort;
  logic               in_valid;
  logic [INSTR_W-1:0] in_data;
  logic               in_ready;
  logic               dec_en;
  logic [INSTR_W-1:0] dec_instr;
  logic               busdir;
  logic               busy;
  logic               done;
  logic               err;

  instr_sequencer #(
    .INSTR_W(INSTR_W),
    .WAIT_W (WAIT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .dec_en    (dec_en),
    .dec_instr (dec_instr),
    .busdir    (busdir),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  logic [31:0] fifo[$];
  logic [31:0] exp_q[$];
  logic [31:0] acc_w[$];
  int          acc_c[$];
  int          dec_c[$];
  int          done_c[$];
  logic        bd_hist[int];
  logic        err_hist[int];
  logic [31:0] mon_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1000;
  endfunction

  // FIFO model: pop on accept at the edge, re-present the head 1 time unit later
  always @(posedge clk) begin
    if (in_valid && in_ready) begin
      acc_w.push_back(fifo.pop_front());
      acc_c.push_back(cyc);
    end
    cyc++;
    #1;
    in_valid = (fifo.size() != 0);
    in_data  = in_valid ? fifo[0] : '0;
  end

  // Monitor: scoreboard check of every issued decoder word, plus history logs
  always @(negedge clk) begin
    bd_hist[cyc]  = busdir;
    err_hist[cyc] = err;
    if (dec_en) begin
      dec_c.push_back(cyc);
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL dec_unexpected: got 0x%08h expected no issue", dec_instr);
      end else begin
        mon_exp = exp_q.pop_front();
        if (dec_instr !== mon_exp) begin
          miscompares++;
          $display("FAIL dec_instr: got 0x%08h expected 0x%08h", dec_instr, mon_exp);
        end
      end
    end
    if (done) done_c.push_back(cyc);
  end

  task automatic clear_logs();
    acc_w.delete();
    acc_c.delete();
    dec_c.delete();
    done_c.delete();
  endtask

  task automatic push_ddr(input logic [31:0] w);
    fifo.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (busy && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    chk(name, busy, 0);
  endtask

  task automatic wait_acc(input string name, input int cnt, input int budget);
    int n;
    n = 0;
    while ((acc_w.size() < cnt) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    chk(name, acc_w.size() >= cnt, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s;
    int n;
    rst_n    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;

    // Reset values
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_dec_en", dec_en, 0);
    chk("rst_dec_instr", dec_instr, 0);
    chk("rst_busdir", busdir, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic sequence: two DDR words back to back, then END
    clear_logs();
    push_ddr(32'h4000_0123);
    push_ddr(32'h4000_0456);
    fifo.push_back(32'hF000_0000);
    pulse_start();
    chk("t1_busy", busy, 1);
    wait_idle("t1_idle", 50);
    chk("t1_busy_fall", cyc - at(done_c, 0), 1);
    chk("t1_done_low", done, 0);
    chk("t1_dec_count", dec_c.size(), 2);
    chk("t1_dec_lat", at(dec_c, 0) - at(acc_c, 0), 1);
    chk("t1_b2b", at(dec_c, 1) - at(dec_c, 0), 1);
    chk("t1_done_count", done_c.size(), 1);
    chk("t1_done_lat", at(done_c, 0) - at(acc_c, 2), 1);

    // WAIT 5 and WAIT 0 between DDR words
    clear_logs();
    push_ddr(32'h4000_0A01);
    fifo.push_back(32'h1000_0005);
    push_ddr(32'h4000_0B02);
    fifo.push_back(32'h1000_0000);
    push_ddr(32'h4000_0C03);
    fifo.push_back(32'hF000_0000);
    pulse_start();
    wait_idle("t2_idle", 60);
    chk("t2_wait5_gap", at(acc_c, 2) - at(acc_c, 1), 6);
    chk("t2_wait0_gap", at(acc_c, 4) - at(acc_c, 3), 1);
    chk("t2_dec_count", dec_c.size(), 3);
    chk("t2_dec_gap_wait5", at(dec_c, 1) - at(dec_c, 0), 7);
    chk("t2_dec_gap_wait0", at(dec_c, 2) - at(dec_c, 1), 2);

    // BUSDIR set and clear
    clear_logs();
    fifo.push_back(32'h2000_0001);
    push_ddr(32'h4000_0D04);
    fifo.push_back(32'h2000_0000);
    fifo.push_back(32'hF000_0000);
    pulse_start();
    wait_idle("t3_idle", 50);
    chk("t3_acc_count", acc_w.size(), 4);
    chk("t3_bd_before_set", bd_hist[at(acc_c, 0)], 0);
    chk("t3_bd_set", bd_hist[at(acc_c, 0) + 1], 1);
    chk("t3_bd_before_clr", bd_hist[at(acc_c, 2)], 1);
    chk("t3_bd_clr", bd_hist[at(acc_c, 2) + 1], 0);

    // Unknown type mid-sequence
    clear_logs();
    push_ddr(32'h4000_0E05);
    fifo.push_back(32'h7000_0000);
    push_ddr(32'h4000_0F06);
    fifo.push_back(32'hF000_0000);
    pulse_start();
    wait_idle("t4_idle", 50);
    chk("t4_err_before", err_hist[at(acc_c, 1)], 0);
    chk("t4_err_set", err_hist[at(acc_c, 1) + 1], 1);
    chk("t4_err_sticky", err, 1);
    chk("t4_dec_count", dec_c.size(), 2);
    chk("t4_done_count", done_c.size(), 1);

    // start together with abort in IDLE: abort wins, err untouched
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("t4b_busy", busy, 0);
    chk("t4b_err_kept", err, 1);

    // Abort during WAIT 100 at count 50
    clear_logs();
    fifo.push_back(32'h1000_0064);
    pulse_start();
    chk("t5_err_cleared", err, 0);
    wait_acc("t5_wait_acc", 1, 10);
    repeat (49) @(negedge clk);
    chk("t5_busy_in_wait", busy, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t5_abort_busy", busy, 0);
    chk("t5_abort_ready", in_ready, 0);
    repeat (3) @(negedge clk);
    chk("t5_stays_idle", busy, 0);
    chk("t5_no_done", done_c.size(), 0);

    // Abort in RUN does not pop the presented word
    clear_logs();
    push_ddr(32'h4000_1007);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b1;
    #1;
    chk("t5_ready_forced_low", in_ready, 0);
    @(negedge clk);
    abort = 1'b0;
    chk("t5_not_popped", acc_w.size(), 0);
    chk("t5_idle_after_run_abort", busy, 0);

    // Restart and issue normally
    @(negedge clk);
    s = cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    fifo.push_back(32'hF000_0000);
    wait_idle("t5_idle", 50);
    chk("t5_restart_lat", at(acc_c, 0) - s, 1);
    chk("t5_dec_count", dec_c.size(), 1);
    chk("t5_done_count", done_c.size(), 1);

    // Asynchronous reset mid-RUN while dec_en is high
    clear_logs();
    push_ddr(32'h4000_1107);
    fifo.push_back(32'h4000_2208);
    pulse_start();
    n = 0;
    while (!dec_en && (n < 10)) begin
      @(negedge clk);
      n++;
    end
    chk("t6_dec_en_seen", dec_en, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_dec_en", dec_en, 0);
    chk("t6_async_dec_instr", dec_instr, 0);
    chk("t6_async_busy", busy, 0);
    chk("t6_async_in_ready", in_ready, 0);
    chk("t6_async_done", done, 0);
    chk("t6_async_err", err, 0);
    chk("t6_async_busdir", busdir, 0);
    @(negedge clk);
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    chk("t6_start_ignored", busy, 0);
    rst_n = 1'b1;
    fifo.delete();
    repeat (2) @(negedge clk);
    chk("t6_idle_after_reset", busy, 0);
    chk("t6_second_not_popped", acc_w.size(), 1);

    chk("exp_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
